// File: rtl/regfile_arb_pkg.sv
// Shared widths, requester indices and FSM encoding for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int REG_NUM_W = 3;
    localparam int DATA_W    = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        SWITCH   = 2'd2,
        WAIT_REL = 2'd3
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_grant_sel.sv
// Grant selection for the writeback arbiter: valid vector in, one-hot grant out.
// Round-robin search from rr_ptr when REGFILE_ARB_RR_EN is defined, otherwise lowest index wins.
module wb_grant_sel #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         valid,
`ifdef REGFILE_ARB_RR_EN
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
`endif
    output logic [N_REQ-1:0]         grant
);

`ifdef REGFILE_ARB_RR_EN
    // Visit requesters in order rr_ptr, rr_ptr+1, ... (mod N_REQ); first valid one wins.
    always_comb begin : rr_sel
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && valid[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin : fixed_sel
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback sources and sequences bank switches.
// Optional round-robin arbitration is enabled by defining REGFILE_ARB_RR_EN.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [REG_NUM_W*N_REQ-1:0]   req_reg,
    input  logic [DATA_W*N_REQ-1:0]      req_data,
    input  logic                         bank_sel_req,
    input  logic                         bank_sel_target,
    output logic                         bank_sel_ack,
    output logic                         wr_en,
    output logic [REG_NUM_W-1:0]         wr_reg,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         active_bank,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    // Handshake: requester i is accepted in a cycle where req_valid[i] && req_ready[i];
    // req_ready is combinational, one-hot at most, and only offered in RUN with no
    // pending bank switch. Requesters hold valid/reg/data stable until accepted.

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    arb_state_e state, state_nxt;
    logic [1:0] drain_cnt, drain_nxt;

    logic [N_REQ-1:0]     grant;
    logic                 grant_en;
    logic                 accept;
    logic [REG_NUM_W-1:0] sel_reg;
    logic [DATA_W-1:0]    sel_data;

`ifdef REGFILE_ARB_RR_EN
    localparam int PTR_W = $clog2(N_REQ);
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;

    wb_grant_sel #(.N_REQ(N_REQ)) u_grant_sel (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    // Pointer moves one past the accepted requester; untouched by bank switches.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                rr_ptr_nxt = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`else
    wb_grant_sel #(.N_REQ(N_REQ)) u_grant_sel (
        .valid (req_valid),
        .grant (grant)
    );
`endif

    assign grant_en     = (state == RUN) && !bank_sel_req;
    assign req_ready    = grant_en ? grant : '0;
    assign accept       = |req_ready;
    assign bank_sel_ack = (state == SWITCH);
    assign busy         = (state != RUN);
    assign state_dbg    = state;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                sel_reg  = req_reg[REG_NUM_W*i +: REG_NUM_W];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (bank_sel_req) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = SWITCH;
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt + 2'd1;
                end
            end
            SWITCH:   state_nxt = WAIT_REL;
            // Wait for the requester to drop its level request so it cannot re-trigger.
            WAIT_REL: begin
                if (!bank_sel_req) begin
                    state_nxt = RUN;
                end
            end
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Register 0 writes are forwarded like any other; the register file needs them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_reg      <= '0;
            wr_data     <= '0;
            active_bank <= 1'b0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_reg  <= sel_reg;
                wr_data <= sel_data;
            end
            if (state == SWITCH) begin
                active_bank <= bank_sel_target;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes queued at issue, checked by a monitor.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_reg;
    logic [31:0] req_data;
    logic        bank_sel_req;
    logic        bank_sel_target;
    logic        bank_sel_ack;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic        active_bank;
    logic        busy;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    logic [18:0] exp_q[$];

    regfile_write_arbiter #(.N_REQ(2), .DRAIN_CYCLES(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_reg         (req_reg),
        .req_data        (req_data),
        .bank_sel_req    (bank_sel_req),
        .bank_sel_target (bank_sel_target),
        .bank_sel_ack    (bank_sel_ack),
        .wr_en           (wr_en),
        .wr_reg          (wr_reg),
        .wr_data         (wr_data),
        .active_bank     (active_bank),
        .busy            (busy),
        .state_dbg       (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] r, input logic [15:0] d);
        req_reg[3*i +: 3]   = r;
        req_data[16*i +: 16] = d;
    endtask

    task automatic bank_switch(input logic tgt, input bit drop_early);
        int  acks;
        bit  idle;
        acks = 0;
        idle = 1'b0;
        step();
        bank_sel_req    = 1'b1;
        bank_sel_target = tgt;
        if (drop_early) begin
            step();
            bank_sel_req = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bank_sel_ack) acks++;
        end
        step();
        bank_sel_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bank_sel_ack) acks++;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("bank_release_idle", 32'(idle), 32'd1);
        check("bank_ack_count", 32'(acks), 32'd1);
        check("bank_active", 32'(active_bank), 32'(tgt));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got reg %0d data %0h, no write expected", wr_reg, wr_data);
            end else begin
                logic [18:0] exp;
                exp = exp_q.pop_front();
                check("wb_write", {13'b0, wr_reg, wr_data}, {13'b0, exp});
            end
        end
    end

    initial begin
        logic [1:0] exp_rdy;
        rst_n           = 1'b0;
        req_valid       = '0;
        req_reg         = '0;
        req_data        = '0;
        bank_sel_req    = 1'b0;
        bank_sel_target = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_active_bank", 32'(active_bank), 32'd0);
        check("rst_ack", 32'(bank_sel_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(RUN));
        #2 rst_n = 1'b1;

        // Single ALU write
        step();
        set_req(REQ_ALU, 3'd3, 16'h1234);
        req_valid = 2'b01;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd3, 16'h1234});
        step();
        req_valid = 2'b00;
        @(negedge clk);
        step();
        @(negedge clk);
        check("single_wr_en_drop", 32'(wr_en), 32'd0);

        // Contention: both requesters valid for four cycles
        step();
        set_req(REQ_ALU, 3'd1, 16'hA001);
        set_req(REQ_LOAD, 3'd2, 16'hB002);
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
`ifdef REGFILE_ARB_RR_EN
            exp_rdy = (c % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b01;
`endif
            @(negedge clk);
            check("contention_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy == 2'b01) exp_q.push_back({3'd1, 16'hA001});
            else                  exp_q.push_back({3'd2, 16'hB002});
            step();
        end
        req_valid = 2'b00;

        // Bank switch during continuous ALU writes
        step();
        set_req(REQ_ALU, 3'd5, 16'h5001);
        req_valid = 2'b01;
        @(negedge clk);
        check("bank_pre_ready0", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd5, 16'h5001});
        step();
        set_req(REQ_ALU, 3'd5, 16'h5002);
        @(negedge clk);
        check("bank_pre_ready1", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd5, 16'h5002});
        step();
        set_req(REQ_ALU, 3'd5, 16'h5003);
        bank_sel_req    = 1'b1;
        bank_sel_target = 1'b1;
        @(negedge clk);
        check("bank_req_blocks_ready", 32'(req_ready), 32'h0);
        check("bank_req_busy_run", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        check("drain_state", 32'(state_dbg), 32'(DRAIN));
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_ready", 32'(req_ready), 32'h0);
        check("drain_ack", 32'(bank_sel_ack), 32'd0);
        step();
        @(negedge clk);
        check("switch_state", 32'(state_dbg), 32'(SWITCH));
        check("switch_ack", 32'(bank_sel_ack), 32'd1);
        check("switch_bank_old", 32'(active_bank), 32'd0);
        step();
        @(negedge clk);
        check("waitrel_state", 32'(state_dbg), 32'(WAIT_REL));
        check("waitrel_ack", 32'(bank_sel_ack), 32'd0);
        check("waitrel_bank", 32'(active_bank), 32'd1);
        check("waitrel_ready", 32'(req_ready), 32'h0);
        step();
        @(negedge clk);
        check("waitrel_hold_state", 32'(state_dbg), 32'(WAIT_REL));
        check("waitrel_hold_ready", 32'(req_ready), 32'h0);
        step();
        bank_sel_req = 1'b0;
        @(negedge clk);
        check("waitrel_release_ready", 32'(req_ready), 32'h0);
        step();
        @(negedge clk);
        check("resume_state", 32'(state_dbg), 32'(RUN));
        check("resume_ready", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd5, 16'h5003});
        step();
        req_valid = 2'b00;

        // Same-bank switch with request dropped during DRAIN
        bank_switch(1'b1, 1'b1);

        // Register 0 write is forwarded
        step();
        set_req(REQ_ALU, 3'd0, 16'h0000);
        req_valid = 2'b01;
        @(negedge clk);
        check("reg0_ready", 32'(req_ready), 32'h1);
        exp_q.push_back({3'd0, 16'h0000});
        step();
        req_valid = 2'b00;
        @(negedge clk);
        step();
        @(negedge clk);
        check("reg0_wr_en_drop", 32'(wr_en), 32'd0);

        // Asynchronous reset with a write on the output
        step();
        set_req(REQ_ALU, 3'd7, 16'hBEEF);
        req_valid = 2'b01;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("rst_mid_pre_wr_en", 32'(wr_en), 32'd1);
        #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_mid_wr_data", 32'(wr_data), 32'd0);
        check("rst_mid_bank", 32'(active_bank), 32'd0);
        check("rst_mid_state", 32'(state_dbg), 32'(RUN));
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_release_no_write", 32'(wr_en), 32'd0);
        end

        // Same-bank switch at bank 0 with request held
        bank_switch(1'b0, 1'b0);

        // Idle requesters
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_wr_en", 32'(wr_en), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Final report
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
